// File: rtl/lcd_pkg.sv
// Shared panel-state encodings and panel command opcodes for the LCD SPI receiver.
package lcd_pkg;

  typedef logic [1:0] panel_state_t;

  localparam panel_state_t PANEL_RESET     = 2'd0;
  localparam panel_state_t PANEL_SLEEP_IN  = 2'd1;
  localparam panel_state_t PANEL_WAKE_WAIT = 2'd2;
  localparam panel_state_t PANEL_AWAKE     = 2'd3;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;

endpackage

// File: rtl/lcd_spi_deser.sv
// Panel-side SPI deserializer: input synchronizers, SCK edge detect, MSB-first
// shifter and mid-byte chip-select abort detection.
module lcd_spi_deser (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCK,
  input  logic       SDA,
  input  logic       DC,
  input  logic       CS,
  input  logic       LCD_RST,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_is_cmd,
  output logic       frame_err,
  output logic       lcd_rst_s
);

  logic [1:0] sck_sync;
  logic [1:0] sda_sync;
  logic [1:0] dc_sync;
  logic [1:0] cs_sync;
  logic [1:0] rst_sync;
  logic       sck_prev;
  logic       cs_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       sck_rise;
  logic       cs_rise;

  // Idle levels out of reset: CS deasserted, SCK low, panel held in reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_sync <= '0;
      sda_sync <= '0;
      dc_sync  <= '0;
      cs_sync  <= '1;
      rst_sync <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[0], SCK};
      sda_sync <= {sda_sync[0], SDA};
      dc_sync  <= {dc_sync[0], DC};
      cs_sync  <= {cs_sync[0], CS};
      rst_sync <= {rst_sync[0], LCD_RST};
      sck_prev <= sck_sync[1];
      cs_prev  <= cs_sync[1];
    end
  end

  assign sck_rise  = sck_sync[1] & ~sck_prev;
  assign cs_rise   = cs_sync[1] & ~cs_prev;
  assign lcd_rst_s = rst_sync[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_is_cmd <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      // Panel reset drops any partial byte without flagging a framing error.
      if (!rst_sync[1]) begin
        bit_cnt <= '0;
      end else if (cs_sync[1]) begin
        bit_cnt <= '0;
        if (cs_rise && (bit_cnt != '0)) begin
          frame_err <= 1'b1;
        end
      end else if (sck_rise) begin
        shift   <= {shift[5:0], sda_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte   <= {shift, sda_sync[1]};
          rx_is_cmd <= ~dc_sync[1];
          rx_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI receiver top: deserializer plus panel command decode, sleep-out wait
// timer, display-on flag and saturating data-byte counter.
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int unsigned SLPOUT_WAIT_CYC = 1440000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SCK,
  input  logic             SDA,
  input  logic             DC,
  input  logic             CS,
  input  logic             LCD_RST,
  output logic [7:0]       RX_BYTE,
  output logic             RX_VALID,
  output logic             RX_IS_CMD,
  output logic             FRAME_ERR,
  output logic             VIOL,
  output logic [1:0]       PANEL_STATE,
  output logic             DISP_ON,
  output logic [CNT_W-1:0] DATA_CNT
);

  localparam int unsigned WAIT_W = (SLPOUT_WAIT_CYC > 1) ? $clog2(SLPOUT_WAIT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLPOUT_WAIT_CYC - 1);

  logic              lcd_rst_s;
  logic              cmd_valid;
  panel_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;

  lcd_spi_deser u_deser (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SCK       (SCK),
    .SDA       (SDA),
    .DC        (DC),
    .CS        (CS),
    .LCD_RST   (LCD_RST),
    .rx_byte   (RX_BYTE),
    .rx_valid  (RX_VALID),
    .rx_is_cmd (RX_IS_CMD),
    .frame_err (FRAME_ERR),
    .lcd_rst_s (lcd_rst_s)
  );

  assign cmd_valid   = RX_VALID & RX_IS_CMD;
  assign PANEL_STATE = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= PANEL_RESET;
      wait_cnt <= '0;
      DISP_ON  <= 1'b0;
      DATA_CNT <= '0;
      VIOL     <= 1'b0;
    end else begin
      VIOL <= 1'b0;
      if (!lcd_rst_s) begin
        state    <= PANEL_RESET;
        wait_cnt <= '0;
        DISP_ON  <= 1'b0;
        DATA_CNT <= '0;
      end else begin
        if (RX_VALID && !RX_IS_CMD && (DATA_CNT != '1)) begin
          DATA_CNT <= DATA_CNT + 1'b1;
        end
        case (state)
          PANEL_RESET: state <= PANEL_SLEEP_IN;
          // Commands are rejected here; the wake timer keeps running regardless.
          PANEL_WAKE_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              state <= PANEL_AWAKE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
            if (cmd_valid) begin
              VIOL <= 1'b1;
            end
          end
          default: begin
            if (cmd_valid) begin
              case (RX_BYTE)
                CMD_SWRESET: begin
                  state   <= PANEL_SLEEP_IN;
                  DISP_ON <= 1'b0;
                end
                CMD_SLPIN: state <= PANEL_SLEEP_IN;
                CMD_SLPOUT: begin
                  if (state == PANEL_SLEEP_IN) begin
                    state    <= PANEL_WAKE_WAIT;
                    wait_cnt <= '0;
                  end
                end
                CMD_DISPON: begin
                  if (state == PANEL_AWAKE) begin
                    DISP_ON <= 1'b1;
                  end
                end
                CMD_DISPOFF: DISP_ON <= 1'b0;
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
